wb_regfile_slave: RTL
=====================

Name: wb_regfile_slave

Overview:
- Parametrised Wishbone B3 slave register file: NUM_REGS x dw registers with byte-lane writes.
- Adds behaviour the current test slave lacks:
  - read-only hardware status registers,
  - per-register write strobes,
  - error response for bad or out-of-range accesses,
  - optional registered-feedback incrementing bursts.
- Sits behind the Wishbone interconnect as the generic control/status block for DSP datapath configuration.

Parameters:
- dw, 32, data width; multiple of 8.
- aw, 32, address width.
- NUM_REGS, 8, register count; power of 2, range 2..64. IDXW = log2(NUM_REGS).
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only; its value comes from hw_dat_i.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- wb_adr_i  in  aw  byte address
- wb_dat_i  in  dw  write data
- wb_sel_i  in  dw/8  byte lane selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type identifier
- wb_bte_i  in  2  burst type extension
- wb_dat_o  out  dw  read data, registered
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error
- wb_rty_o  out  1  retry; constant 0
- reg_q_o  out  NUM_REGS*dw  flattened RW register contents; register i at [i*dw +: dw]
- hw_dat_i  in  NUM_REGS*dw  status values for RO registers; lanes of RW registers are ignored
- wr_pulse_o  out  NUM_REGS  one-cycle strobe per register on committed write

Behaviour:
- Reset: wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o, wr_pulse_o, all RW registers = 0; FSM = IDLE.
- Reset mid-cycle: outputs clear on the next edge; any in-flight write is discarded.
- Decode:
  - idx = wb_adr_i[IDXW+1:2].
  - Access is bad if wb_adr_i[aw-1:IDXW+2] != 0, or if it is a write to a register with RO_MASK[idx] = 1.
  - wb_adr_i[1:0] are ignored.
- FSM IDLE:
  - On cyc & stb, respond next cycle: wb_ack_o = 1 (good access) or wb_err_o = 1 (bad access); never both.
  - Classic cycle (cti = 000 or 111, or burst disabled): go to RESP.
- FSM RESP:
  - ack/err drop to 0 for exactly one cycle, then return to IDLE.
  - Classic-cycle latency is one cycle; a held stb sees ack pulse 1,0,1,0.
- Write commit: at the edge where the request is sampled in IDLE (same edge ack rises).
  - Byte lane b is updated only if wb_sel_i[b] = 1.
  - wr_pulse_o[idx] = 1 for that one cycle; no pulse on err.
- Read:
  - wb_dat_o loaded at the same edge as ack.
  - Returns the RW register, or hw_dat_i lane for an RO register.
  - wb_dat_o is held otherwise.
  - Read of an out-of-range address returns err and leaves wb_dat_o unchanged.
- Simultaneous write and read-back of the same register: the read in the following access sees the new value.
- cyc dropped while in RESP or BURST: go to IDLE next edge; no further ack.

Optional Feature:
- Macro: WB_REGFILE_BURST_EN.
- Defined:
  - cti = 010 in IDLE enters BURST. ack stays high on consecutive cycles while cyc & stb & cti = 010.
  - Internal address counter advances by 4 per ack.
  - Wrap by bte: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16 beats; low address bits wrap within the aligned block.
  - Each acked beat commits a write or presents the next read datum.
  - cti = 111 beat: final ack, then RESP.
  - Counter leaving the valid range: err on that beat, then RESP.
- Undefined: cti and bte are ignored; every access follows the classic path.

Decomposition:
- Shared package wb_pkg:
  - CTI_CLASSIC/CTI_INCR/CTI_EOB constants,
  - BTE_LINEAR/BTE_WRAP4/8/16 constants,
  - FSM state encoding,
  - function to compute the next burst address.
- One natural sub-module: wb_byte_en_reg — a single dw register with byte enables, instantiated per RW register.

Test Plan:
- Reset: assert wb_rst 2 cycles -> all reg_q_o = 0, ack/err/dat_o = 0, wr_pulse_o = 0.
- Classic write 0xDEADBEEF to 0x4, sel = 0011 -> reg1 = 0x0000BEEF; wr_pulse_o = 0x02 for 1 cycle; ack 1 cycle after stb; read of 0x4 returns 0x0000BEEF.
- RO_MASK = 0x01, hw_dat_i[31:0] = 0x12345678:
  - read 0x0 -> 0x12345678 with ack;
  - write 0x0 -> err, no ack, no pulse, reg unchanged.
- Out-of-range (NUM_REGS = 8): write to 0x20 -> err = 1 one cycle; read of 0x40 -> err, wb_dat_o holds its previous value.
- Burst (WB_REGFILE_BURST_EN): write 4 beats at 0x18, cti 010,010,010,111, bte = 01:
  - continuous ack;
  - regs 6, 7, 4, 5 written (wrap-4);
  - ack drops after the EOB beat.
- Reset mid-burst at beat 2 -> ack = 0 next edge; FSM IDLE; registers = 0.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared Wishbone constants, slave FSM encoding and burst address
//          helper for the register-file slave.
// Rev    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_BURST = 2'd2
    } wb_state_t;

    // Wrapping bursts only let the low address bits roll over inside the
    // aligned 4/8/16-beat block; the upper bits stay fixed.
    function automatic logic [63:0] next_burst_adr(input logic [63:0] adr,
                                                   input logic [1:0]  bte);
        logic [63:0] inc;
        inc = adr + 64'd4;
        case (bte)
            BTE_WRAP4:  return {adr[63:4], inc[3:0]};
            BTE_WRAP8:  return {adr[63:5], inc[4:0]};
            BTE_WRAP16: return {adr[63:6], inc[5:0]};
            default:    return inc;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_byte_en_reg.sv
`default_nettype none
// ============================================================================
// Module : wb_byte_en_reg
// Brief  : One dw-bit register with per-byte write enables.
// Rev    : 1.0  initial release
// ============================================================================
module wb_byte_en_reg #(
    parameter int dw = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [dw/8-1:0] sel,
    input  logic [dw-1:0]   wdata,
    output logic [dw-1:0]   q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < dw/8; b++) begin
                if (sel[b]) begin
                    q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_slave
// Brief  : Wishbone B3 register-file slave with byte-lane writes, read-only
//          status registers, write strobes and error responses. Define
//          WB_REGFILE_BURST_EN to enable registered-feedback incrementing bursts.
// Rev    : 1.0  initial release
// ============================================================================
module wb_regfile_slave
    import wb_pkg::*;
#(
    parameter int                  dw       = 32,
    parameter int                  aw       = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = {NUM_REGS{1'b0}}
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [aw-1:0]          wb_adr_i,
    input  logic [dw-1:0]          wb_dat_i,
    input  logic [dw/8-1:0]        wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic [2:0]             wb_cti_i,
    input  logic [1:0]             wb_bte_i,
    output logic [dw-1:0]          wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic [NUM_REGS*dw-1:0] reg_q_o,
    input  logic [NUM_REGS*dw-1:0] hw_dat_i,
    output logic [NUM_REGS-1:0]    wr_pulse_o
);

    localparam int IDXW = $clog2(NUM_REGS);

    wb_state_t       r_state;
    logic [aw-1:0]   w_beat_adr;
    logic [IDXW-1:0] w_idx;
    logic            w_oor;
    logic            w_bad;
    logic            w_req;
    logic            w_commit;
    logic [dw-1:0]   w_word [NUM_REGS];
    logic            w_unused;

`ifdef WB_REGFILE_BURST_EN
    logic [aw-1:0]   r_adr;
    logic [aw-1:0]   w_adr_next;
    assign w_adr_next = aw'(next_burst_adr(64'(w_beat_adr), wb_bte_i));
`endif

    assign wb_rty_o = 1'b0;
    assign w_unused = ^{wb_cti_i, wb_bte_i, w_beat_adr[1:0], hw_dat_i};

    // Inside a burst the slave follows its own address counter.
    always_comb begin
        w_beat_adr = wb_adr_i;
`ifdef WB_REGFILE_BURST_EN
        if (r_state == ST_BURST) begin
            w_beat_adr = r_adr;
        end
`endif
        w_idx    = w_beat_adr[IDXW+1:2];
        w_oor    = |w_beat_adr[aw-1:IDXW+2];
        w_bad    = w_oor | (wb_we_i & RO_MASK[w_idx]);
        w_req    = wb_cyc_i & wb_stb_i & ((r_state == ST_IDLE) | (r_state == ST_BURST));
        w_commit = w_req & wb_we_i & ~w_bad & ~wb_rst;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign w_word[i]              = hw_dat_i[i*dw +: dw];
            assign reg_q_o[i*dw +: dw]    = '0;
        end else begin : g_rw
            wb_byte_en_reg #(
                .dw    (dw)
            ) u_reg (
                .clk   (wb_clk),
                .rst   (wb_rst),
                .wr_en (w_commit && (w_idx == IDXW'(i))),
                .sel   (wb_sel_i),
                .wdata (wb_dat_i),
                .q     (w_word[i])
            );
            assign reg_q_o[i*dw +: dw] = w_word[i];
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state    <= ST_IDLE;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
            wr_pulse_o <= '0;
`ifdef WB_REGFILE_BURST_EN
            r_adr      <= '0;
`endif
        end else begin
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wr_pulse_o <= w_commit ? (NUM_REGS'(1) << w_idx) : '0;
            if (w_req) begin
                wb_ack_o <= ~w_bad;
                wb_err_o <= w_bad;
                if (!wb_we_i && !w_bad) begin
                    wb_dat_o <= w_word[w_idx];
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        r_state <= ST_RESP;
`ifdef WB_REGFILE_BURST_EN
                        if (!w_bad && wb_cti_i == CTI_INCR) begin
                            r_state <= ST_BURST;
                            r_adr   <= w_adr_next;
                        end
`endif
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
`ifdef WB_REGFILE_BURST_EN
                // An EOB, a non-incrementing beat or an error ends the burst.
                ST_BURST: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (wb_stb_i) begin
                        if (!w_bad && wb_cti_i == CTI_INCR) begin
                            r_adr <= w_adr_next;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
